// File: rtl/param_if_endpoint.sv
// Parameterised endpoint: per-slot data bits, constant FOO/BAR outputs, and a registered parameter query port.
// Latency: data writes take effect on the next edge; query responses arrive exactly one cycle after the request.
// Backpressure: none; a query may be issued every cycle. Optional macro PARAM_IF_GETFOO_EN builds the get_foo accessor.
module param_if_endpoint #(
    parameter int FOO    = 1,
    parameter int N_SLOT = 2,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [31:0]       foo_o,
    output logic [31:0]       bar_o,
    output logic [31:0]       foo_cat_bits_o,
    input  logic              data_we,
    input  logic [IDX_W-1:0]  data_idx,
    input  logic              data_d,
    output logic [N_SLOT-1:0] data_q,
    input  logic              qry_valid,
    input  logic [1:0]        qry_sel,
    input  logic [IDX_W-1:0]  qry_idx,
    output logic              qry_rvalid,
    output logic [31:0]       qry_rdata,
    output logic              qry_err
);

    // BAR is formed on a 32-bit vector so FOO = INT_MAX wraps to INT_MIN without elaboration overflow.
    localparam logic [31:0] FOO_BITS = FOO;
    localparam logic [31:0] BAR_BITS = FOO_BITS + 32'd1;
    localparam int          CAT_W    = $bits({FOO_BITS, FOO_BITS});

    assign foo_o          = FOO_BITS;
    assign bar_o          = BAR_BITS;
    assign foo_cat_bits_o = 32'(CAT_W);

`ifdef PARAM_IF_GETFOO_EN
    // Accessor path for sel2; kept separate from the direct FOO constant on purpose.
    function automatic logic [31:0] get_foo();
        return FOO_BITS;
    endfunction
`endif

    logic        qry_idx_ok;
    logic [31:0] rdata_nxt;
    logic        err_nxt;

    assign qry_idx_ok = (32'(qry_idx) < N_SLOT);

    // Response value and error for the current request; never depends on data_q.
    always_comb begin
        rdata_nxt = 32'd0;
        err_nxt   = 1'b0;
        if (!qry_idx_ok) begin
            err_nxt = 1'b1;
        end else begin
            case (qry_sel)
                2'd0: rdata_nxt = FOO_BITS;
                2'd1: rdata_nxt = BAR_BITS;
`ifdef PARAM_IF_GETFOO_EN
                2'd2: rdata_nxt = get_foo();
`else
                2'd2: err_nxt   = 1'b1;
`endif
                default: rdata_nxt = 32'(CAT_W);
            endcase
        end
    end

    // Per-slot data bits; out-of-range indices match no slot and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            for (int i = 0; i < N_SLOT; i++) begin
                if (data_we && (32'(data_idx) == i)) begin
                    data_q[i] <= data_d;
                end
            end
        end
    end

    // One-cycle query response; rdata/err hold between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qry_rvalid <= 1'b0;
            qry_rdata  <= 32'd0;
            qry_err    <= 1'b0;
        end else begin
            qry_rvalid <= qry_valid;
            if (qry_valid) begin
                qry_rdata <= rdata_nxt;
                qry_err   <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_param_if_endpoint.sv
module tb_param_if_endpoint;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_we = 1'b0;
    logic [3:0] data_idx = 4'd0;
    logic       data_d = 1'b0;
    logic       qry_valid = 1'b0;
    logic [1:0] qry_sel = 2'd0;
    logic [3:0] qry_idx = 4'd0;

    // FOO=5 instance
    logic [31:0] foo_o, bar_o, cat_o, rdata;
    logic [1:0]  data_q;
    logic        rvalid, err;
    // FOO=7 instance
    logic [31:0] foo7, bar7, cat7, rdata7;
    logic [1:0]  data_q7;
    logic        rvalid7, err7;
    // FOO=INT_MAX instance
    logic [31:0] foom, barm, catm, rdatam;
    logic [1:0]  data_qm;
    logic        rvalidm, errm;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    param_if_endpoint #(.FOO(5), .N_SLOT(2), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .foo_o(foo_o), .bar_o(bar_o), .foo_cat_bits_o(cat_o),
        .data_we(data_we), .data_idx(data_idx), .data_d(data_d), .data_q(data_q),
        .qry_valid(qry_valid), .qry_sel(qry_sel), .qry_idx(qry_idx),
        .qry_rvalid(rvalid), .qry_rdata(rdata), .qry_err(err)
    );

    param_if_endpoint #(.FOO(7), .N_SLOT(2), .IDX_W(4)) dut7 (
        .clk(clk), .rst(rst), .foo_o(foo7), .bar_o(bar7), .foo_cat_bits_o(cat7),
        .data_we(data_we), .data_idx(data_idx), .data_d(data_d), .data_q(data_q7),
        .qry_valid(qry_valid), .qry_sel(qry_sel), .qry_idx(qry_idx),
        .qry_rvalid(rvalid7), .qry_rdata(rdata7), .qry_err(err7)
    );

    param_if_endpoint #(.FOO(2147483647), .N_SLOT(2), .IDX_W(4)) dutm (
        .clk(clk), .rst(rst), .foo_o(foom), .bar_o(barm), .foo_cat_bits_o(catm),
        .data_we(data_we), .data_idx(data_idx), .data_d(data_d), .data_q(data_qm),
        .qry_valid(qry_valid), .qry_sel(qry_sel), .qry_idx(qry_idx),
        .qry_rvalid(rvalidm), .qry_rdata(rdatam), .qry_err(errm)
    );

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        tests++; if (data_q !== 2'b00) begin fails++; $display("FAIL reset_data_q got %b exp 00", data_q); end
        tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
        tests++; if (rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got %0d exp 0", rdata); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
        tests++; if (foo_o !== 32'd5) begin fails++; $display("FAIL const_foo got %0d exp 5", foo_o); end
        tests++; if (bar_o !== 32'd6) begin fails++; $display("FAIL const_bar got %0d exp 6", bar_o); end
        tests++; if (cat_o !== 32'd64) begin fails++; $display("FAIL const_cat got %0d exp 64", cat_o); end
        tests++; if (foo7 !== 32'd7 || bar7 !== 32'd8) begin fails++; $display("FAIL const_foo7 got %0d/%0d exp 7/8", foo7, bar7); end
        tests++; if (barm !== 32'h8000_0000) begin fails++; $display("FAIL const_bar_wrap got %h exp 80000000", barm); end
        tests++; if (foom !== 32'h7fff_ffff) begin fails++; $display("FAIL const_foo_max got %h exp 7fffffff", foom); end
        rst = 1'b0;
    endtask

    task automatic test_query_basic();
        logic [1:0]  sels [3];
        logic [31:0] exp5 [3];
        logic [31:0] exp7 [3];
        sels = '{2'd0, 2'd1, 2'd3};
        exp5 = '{32'd5, 32'd6, 32'd64};
        exp7 = '{32'd7, 32'd8, 32'd64};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            qry_valid = 1'b1; qry_sel = sels[i]; qry_idx = 4'd0;
            // request alone must not produce a response before the edge
            #1;
            tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL q_early_rvalid sel%0d got %b exp 0", sels[i], rvalid); end
            @(negedge clk);
            qry_valid = 1'b0;
            tests++; if (rvalid !== 1'b1) begin fails++; $display("FAIL q_rvalid sel%0d got %b exp 1", sels[i], rvalid); end
            tests++; if (rdata !== exp5[i] || err !== 1'b0) begin fails++; $display("FAIL q_rdata5 sel%0d got %0d err %b exp %0d err 0", sels[i], rdata, err, exp5[i]); end
            tests++; if (rdata7 !== exp7[i] || err7 !== 1'b0) begin fails++; $display("FAIL q_rdata7 sel%0d got %0d err %b exp %0d err 0", sels[i], rdata7, err7, exp7[i]); end
        end
        @(negedge clk);
        tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL q_idle_rvalid got %b exp 0", rvalid); end
        tests++; if (rdata !== 32'd64) begin fails++; $display("FAIL q_hold_rdata got %0d exp 64", rdata); end
    endtask

    task automatic test_query_idx();
        // idx1 in range
        qry_valid = 1'b1; qry_sel = 2'd1; qry_idx = 4'd1;
        @(negedge clk);
        tests++; if (rdata7 !== 32'd8 || err7 !== 1'b0 || rvalid7 !== 1'b1) begin fails++; $display("FAIL idx1_sel1 got %0d err %b v %b exp 8 err 0 v 1", rdata7, err7, rvalid7); end
        qry_sel = 2'd0;
        @(negedge clk);
        tests++; if (rdata7 !== 32'd7 || err7 !== 1'b0) begin fails++; $display("FAIL idx1_sel0 got %0d err %b exp 7 err 0", rdata7, err7); end
        // idx2 out of range
        qry_idx = 4'd2;
        @(negedge clk);
        tests++; if (rdata7 !== 32'd0 || err7 !== 1'b1 || rvalid7 !== 1'b1) begin fails++; $display("FAIL idx2_err got %0d err %b v %b exp 0 err 1 v 1", rdata7, err7, rvalid7); end
        qry_idx = 4'd15; qry_sel = 2'd3;
        @(negedge clk);
        tests++; if (rdata !== 32'd0 || err !== 1'b1) begin fails++; $display("FAIL idx15_err got %0d err %b exp 0 err 1", rdata, err); end
        qry_valid = 1'b0; qry_idx = 4'd0;
        @(negedge clk);
        tests++; if (err !== 1'b1 || rvalid !== 1'b0) begin fails++; $display("FAIL err_hold got err %b v %b exp err 1 v 0", err, rvalid); end
    endtask

    task automatic test_data_write();
        data_we = 1'b1; data_idx = 4'd1; data_d = 1'b1;
        // concurrent query must be unaffected
        qry_valid = 1'b1; qry_sel = 2'd0; qry_idx = 4'd0;
        @(negedge clk);
        qry_valid = 1'b0;
        tests++; if (data_q !== 2'b10) begin fails++; $display("FAIL wr_idx1 got %b exp 10", data_q); end
        tests++; if (rdata !== 32'd5 || err !== 1'b0) begin fails++; $display("FAIL wr_concurrent_q got %0d err %b exp 5 err 0", rdata, err); end
        data_idx = 4'd0; data_d = 1'b0;
        @(negedge clk);
        tests++; if (data_q !== 2'b10) begin fails++; $display("FAIL wr_idx0 got %b exp 10", data_q); end
        data_idx = 4'd0; data_d = 1'b1;
        @(negedge clk);
        tests++; if (data_q !== 2'b11) begin fails++; $display("FAIL wr_idx0_set got %b exp 11", data_q); end
        data_idx = 4'd0; data_d = 1'b0;
        @(negedge clk);
        data_idx = 4'd3; data_d = 1'b1;
        @(negedge clk);
        tests++; if (data_q !== 2'b10) begin fails++; $display("FAIL wr_idx3_ignored got %b exp 10", data_q); end
        data_we = 1'b0; data_idx = 4'd1; data_d = 1'b0;
        @(negedge clk);
        tests++; if (data_q !== 2'b10) begin fails++; $display("FAIL wr_we_low_hold got %b exp 10", data_q); end
        // asynchronous reset clears immediately, before any edge
        #2 rst = 1'b1;
        #1;
        tests++; if (data_q !== 2'b00) begin fails++; $display("FAIL async_rst_data got %b exp 00", data_q); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3];
        logic        exp_e [3];
`ifdef PARAM_IF_GETFOO_EN
        exp_d = '{32'd5, 32'd6, 32'd5};
        exp_e = '{1'b0, 1'b0, 1'b0};
`else
        exp_d = '{32'd5, 32'd6, 32'd0};
        exp_e = '{1'b0, 1'b0, 1'b1};
`endif
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            qry_valid = 1'b1; qry_sel = 2'(i); qry_idx = 4'd1;
            @(negedge clk);
            tests++; if (rvalid !== 1'b1 || rdata !== exp_d[i] || err !== exp_e[i]) begin
                fails++; $display("FAIL b2b_%0d got v %b d %0d e %b exp v 1 d %0d e %b", i, rvalid, rdata, err, exp_d[i], exp_e[i]);
            end
        end
        qry_valid = 1'b0;
        @(negedge clk);
        tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL b2b_end_rvalid got %b exp 0", rvalid); end
    endtask

    task automatic test_rst_abort();
        qry_valid = 1'b1; qry_sel = 2'd1; qry_idx = 4'd0;
        @(negedge clk);
        tests++; if (rvalid !== 1'b1 || rdata !== 32'd6) begin fails++; $display("FAIL pre_abort got v %b d %0d exp v 1 d 6", rvalid, rdata); end
        qry_sel = 2'd3;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        tests++; if (rvalid !== 1'b0 || rdata !== 32'd0 || err !== 1'b0) begin fails++; $display("FAIL abort got v %b d %0d e %b exp v 0 d 0 e 0", rvalid, rdata, err); end
        @(negedge clk);
        qry_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL post_abort_rvalid got %b exp 0", rvalid); end
    endtask

    initial begin
        test_reset();
        test_query_basic();
        test_query_idx();
        test_data_write();
        test_back_to_back();
        test_rst_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_if_endpoint.md
Name: param_if_endpoint

Overview:
- Parameterised interface endpoint holding a per-slot `data` bit.
- Exposes its elaboration-time constants FOO and BAR = FOO+1 as constant outputs.
- Also serves them through a registered one-cycle query port, including a `get_foo` accessor path.
- Sits between a producer that owns `data` (output-modport side) and consumers that read the parameters at run time.

Parameters:
- FOO, 1, signed 32-bit integer constant carried by the endpoint.
- N_SLOT, 2, number of endpoint slots (array size); must be 1..16. All slots share FOO.
- IDX_W, 4, width of the slot index.

Ports:
- clk  input  1  single clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- foo_o  output  32  constant FOO.
- bar_o  output  32  constant BAR = FOO+1, computed with 32-bit signed wrap.
- foo_cat_bits_o  output  32  constant 64, the bit width of {FOO,FOO}.
- data_we  input  1  write strobe for the slot `data` bit.
- data_idx  input  IDX_W  slot selected for the write.
- data_d  input  1  write value.
- data_q  output  N_SLOT  registered `data` bit of every slot.
- qry_valid  input  1  query request; may be asserted every cycle.
- qry_sel  input  2  query select: 0 = FOO, 1 = BAR, 2 = get_foo accessor, 3 = bit width of {FOO,FOO}.
- qry_idx  input  IDX_W  slot queried.
- qry_rvalid  output  1  response valid.
- qry_rdata  output  32  response value.
- qry_err  output  1  response error flag.

Behaviour:
- Reset (asynchronous, active-high): data_q = 0, qry_rvalid = 0, qry_rdata = 0, qry_err = 0.
- Constant outputs do not depend on rst or clk.
- Data write:
  - When data_we=1 and data_idx < N_SLOT, data_q[data_idx] <= data_d.
  - When data_idx >= N_SLOT, the write is ignored with no side effect.
  - Other slots hold their value.
- Query latency is exactly 1 cycle:
  - qry_rvalid(t+1) = qry_valid(t).
  - qry_rdata and qry_err are updated only when qry_valid=1.
  - qry_rdata and qry_err hold their last value while qry_rvalid=0.
- Query values:
  - sel0 → FOO.
  - sel1 → FOO+1.
  - sel2 → FOO, through a separate accessor function path.
  - sel3 → 64.
- Query index:
  - qry_idx >= N_SLOT → qry_err=1, qry_rdata=0.
  - Otherwise qry_err=0.
- Back-to-back queries produce back-to-back responses in order; there is no backpressure.
- A data write and a query in the same cycle are independent.
- Query values never depend on data_q.
- rst asserted mid-query aborts the query: qry_rvalid=0 in the following cycle.
- FOO = 2147483647 makes BAR wrap to -2147483648.

Optional Feature:
- Macro: PARAM_IF_GETFOO_EN.
- Defined: sel2 is served by the accessor path and returns FOO.
- Undefined:
  - The accessor path is not built.
  - sel2 responds with qry_err=1 and qry_rdata=0; the response is still delivered 1 cycle later.
  - All other selects are unchanged.

Test Plan:
- FOO=5: after reset, foo_o=5, bar_o=6, foo_cat_bits_o=64; queries sel0/sel1/sel3 on idx0 → rdata 5/6/64, err=0, each one cycle after request.
- FOO=7, N_SLOT=2: query idx0 sel0 and sel1 → 7 and 8; query idx1 → the same values; query idx2 → err=1, rdata=0.
- Write data_d=1 to idx1, then 0 to idx0, then attempt idx3 → data_q=2'b10 and no change from the idx3 write; assert rst mid-sequence → data_q=0 immediately.
- Queries on 3 consecutive cycles with sel 0,1,2 → rvalid high for 3 cycles with rdata 5,6,5 when PARAM_IF_GETFOO_EN is defined; with it undefined, the third response has err=1, rdata=0.
- Query issued, then rst asserted before the next edge → qry_rvalid=0, qry_rdata=0 after the edge.
- FOO=2147483647 → bar_o = 0x80000000.
